// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage plus MEM/WB register of the 5-stage core.
// Runs loads/stores over a dmem req/ack handshake, stalls upstream, aborts hung accesses.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid, alu_in, st_data,       EX/MEM bundle
//   pc_plus4_in, reg_dest_in,
//   mem_rd, mem_wr, wb_sel_in,
//   reg_wr_in, call_in
//   stall                            hold EX/MEM and earlier stages
//   dmem_req/we/addr/wdata           data memory request side
//   dmem_rdata, dmem_ack             data memory response side
//   mem_out, alu_out, pc_plus4,      registered MEM/WB bundle
//   reg_dest, wb_sel, reg_wr, call
//   mem_err                          one-cycle pulse on timeout abort

module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_in,
    input  logic [31:0] st_data,
    input  logic [31:0] pc_plus4_in,
    input  logic [3:0]  reg_dest_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        wb_sel_in,
    input  logic        reg_wr_in,
    input  logic        call_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] mem_out,
    output logic [31:0] alu_out,
    output logic [31:0] pc_plus4,
    output logic [3:0]  reg_dest,
    output logic        wb_sel,
    output logic        reg_wr,
    output logic        call,
    output logic        mem_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Bundle carried from EX/MEM into MEM/WB
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [3:0]  rd;
        logic        wb_sel;
        logic        reg_wr;
        logic        call;
    } bndl_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    bndl_t         lat_q, lat_d;
    bndl_t         wb_q, wb_d;
    logic [31:0]   mem_q, mem_d;
    logic          err_q, err_d;

    logic  access_op;
    bndl_t in_b;

    assign access_op = in_valid & (mem_rd | mem_wr);

    always_comb begin
        in_b        = '0;
        in_b.alu    = alu_in;
        in_b.pc4    = pc_plus4_in;
        in_b.rd     = reg_dest_in;
        in_b.wb_sel = wb_sel_in;
        in_b.reg_wr = reg_wr_in;
        in_b.call   = call_in;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        lat_d   = lat_q;
        wb_d    = wb_q;
        mem_d   = mem_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                mem_d = '0;
                if (access_op) begin
                    addr_d  = {alu_in[31:2], 2'b00};
                    wdata_d = st_data;
                    // both rd and wr set is treated as a store
                    we_d    = mem_wr;
                    lat_d   = in_b;
                    wb_d    = '0;
                    state_d = ACCESS;
                end else if (in_valid) begin
                    wb_d = in_b;
                end else begin
                    wb_d = '0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // ack beats a coincident timeout
                if (dmem_ack) begin
                    wb_d    = lat_q;
                    mem_d   = we_q ? 32'd0 : dmem_rdata;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    wb_d    = '0;
                    mem_d   = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            lat_q   <= '0;
            wb_q    <= '0;
            mem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            lat_q   <= lat_d;
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            err_q   <= err_d;
        end
    end

    assign stall      = (state_q == ACCESS) | ((state_q == IDLE) & access_op);
    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    assign mem_out  = mem_q;
    assign alu_out  = wb_q.alu;
    assign pc_plus4 = wb_q.pc4;
    assign reg_dest = wb_q.rd;
    assign wb_sel   = wb_q.wb_sel;
    assign reg_wr   = wb_q.reg_wr;
    assign call     = wb_q.call;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard queue of expected
// MEM/WB bundles and a separate negedge monitor that pops and compares.

module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_in;
    logic [31:0] st_data;
    logic [31:0] pc_plus4_in;
    logic [3:0]  reg_dest_in;
    logic        mem_rd;
    logic        mem_wr;
    logic        wb_sel_in;
    logic        reg_wr_in;
    logic        call_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] mem_out;
    logic [31:0] alu_out;
    logic [31:0] pc_plus4;
    logic [3:0]  reg_dest;
    logic        wb_sel;
    logic        reg_wr;
    logic        call;
    logic        mem_err;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .alu_in(alu_in), .st_data(st_data), .pc_plus4_in(pc_plus4_in),
        .reg_dest_in(reg_dest_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wb_sel_in(wb_sel_in), .reg_wr_in(reg_wr_in), .call_in(call_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_out(mem_out), .alu_out(alu_out), .pc_plus4(pc_plus4),
        .reg_dest(reg_dest), .wb_sel(wb_sel), .reg_wr(reg_wr),
        .call(call), .mem_err(mem_err)
    );

    typedef struct {
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [3:0]  rd;
        logic        wb_sel;
        logic        reg_wr;
        logic        call;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_n, req_n, we_n;
    int   err_seen = 0;
    int   err_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: any non-bubble WB bundle must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_err) err_seen++;
            if ((|{mem_out, alu_out, pc_plus4, reg_dest}) |
                wb_sel | reg_wr | call) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got alu=0x%08h mem=0x%08h reg_wr=%0b required no writeback",
                             alu_out, mem_out, reg_wr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (mem_out !== e.mem || alu_out !== e.alu ||
                        pc_plus4 !== e.pc4 || reg_dest !== e.rd ||
                        wb_sel !== e.wb_sel || reg_wr !== e.reg_wr ||
                        call !== e.call) begin
                        errors++;
                        $display("FAIL wb_bundle: got mem=%h alu=%h pc4=%h rd=%0d ws=%0b rw=%0b c=%0b required mem=%h alu=%h pc4=%h rd=%0d ws=%0b rw=%0b c=%0b",
                                 mem_out, alu_out, pc_plus4, reg_dest, wb_sel, reg_wr, call,
                                 e.mem, e.alu, e.pc4, e.rd, e.wb_sel, e.reg_wr, e.call);
                    end
                end
            end
        end
    end

    task automatic push(input logic [31:0] m, input logic [31:0] a,
                        input logic [31:0] p, input logic [3:0] r,
                        input logic ws, input logic rw, input logic c);
        exp_t e;
        e.mem = m; e.alu = a; e.pc4 = p; e.rd = r;
        e.wb_sel = ws; e.reg_wr = rw; e.call = c;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] p,
                         input logic [3:0] r, input logic rd_op,
                         input logic wr_op, input logic ws,
                         input logic rw, input logic c);
        in_valid = v; alu_in = a; st_data = sd; pc_plus4_in = p;
        reg_dest_in = r; mem_rd = rd_op; mem_wr = wr_op;
        wb_sel_in = ws; reg_wr_in = rw; call_in = c;
    endtask

    task automatic idle_in();
        drive(1'b0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        stall_n = 0; req_n = 0; we_n = 0;
    endtask

    // Sample combinational outputs late in the cycle, then advance
    task automatic tick();
        #3;
        if (stall) stall_n++;
        if (dmem_req) req_n++;
        if (dmem_req && dmem_we) we_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        idle_in();
        #1;
        check("rst_alu_out", alu_out, 0);
        check("rst_reg_wr", {31'd0, reg_wr}, 0);
        check("rst_dmem_req", {31'd0, dmem_req}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_mem_err", {31'd0, mem_err}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Plain ALU op: one-cycle latency, never stalls
        clr();
        drive(1'b1, 32'h10, 0, 0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(0, 32'h10, 0, 4'd3, 1'b0, 1'b1, 1'b0);
        tick();
        idle_in();
        tick();
        check("alu_stall_cycles", stall_n, 0);

        // Invalid input with junk fields yields a bubble
        drive(1'b0, 32'h99, 0, 32'h4, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle_in();
        tick();

        // Load 0x103, ack on third ACCESS cycle
        clr();
        drive(1'b1, 32'h103, 0, 0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check("ld_stall_comb", {31'd0, stall}, 1);
        check("ld_req_idle", {31'd0, dmem_req}, 0);
        tick();
        idle_in();
        check("ld_addr", dmem_addr, 32'h100);
        check("ld_we", {31'd0, dmem_we}, 0);
        tick();
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        push(32'hDEADBEEF, 32'h103, 0, 4'd5, 1'b1, 1'b1, 1'b0);
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        tick();
        check("ld_stall_cycles", stall_n, 4);
        check("ld_req_cycles", req_n, 3);

        // Store 0x20 <- 0x55, immediate ack
        clr();
        drive(1'b1, 32'h20, 32'h55, 0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        check("st_addr", dmem_addr, 32'h20);
        check("st_wdata", dmem_wdata, 32'h55);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF0000;
        push(0, 32'h20, 0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        dmem_ack = 1'b0;
        tick();
        check("st_we_cycles", we_n, 1);
        check("st_stall_cycles", stall_n, 2);

        // rd and wr both set: store, mem_out stays 0 despite rdata
        clr();
        drive(1'b1, 32'h7, 32'hA5, 0, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        check("rw_we", {31'd0, dmem_we}, 1);
        check("rw_addr", dmem_addr, 32'h4);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234;
        push(0, 32'h7, 0, 4'd6, 1'b1, 1'b1, 1'b0);
        tick();
        dmem_ack = 1'b0;
        tick();

        // Ack while idle is ignored
        clr();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h77;
        tick();
        tick();
        dmem_ack = 1'b0;
        check("idle_ack_req", req_n, 0);

        // Load with no ack: abort after 16 request cycles
        clr();
        err_base = err_seen;
        drive(1'b1, 32'h40, 0, 0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        repeat (20) tick();
        check("to_req_cycles", req_n, 16);
        check("to_stall_cycles", stall_n, 17);
        check("to_err_pulses", err_seen - err_base, 1);

        // Ack coincides with last allowed cycle: normal completion
        clr();
        err_base = err_seen;
        drive(1'b1, 32'h48, 0, 0, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        repeat (15) tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        push(32'h0BADF00D, 32'h48, 0, 4'd10, 1'b1, 1'b1, 1'b0);
        tick();
        dmem_ack = 1'b0;
        tick();
        check("tie_req_cycles", req_n, 16);
        check("tie_err_pulses", err_seen - err_base, 0);

        // Reset in the middle of an access
        clr();
        drive(1'b1, 32'h80, 0, 0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        check("rr_req_before", {31'd0, dmem_req}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_req_async", {31'd0, dmem_req}, 0);
        check("rr_stall_async", {31'd0, stall}, 0);
        check("rr_reg_wr_async", {31'd0, reg_wr}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h111;
        tick();
        tick();
        dmem_ack = 1'b0;
        check("rr_late_ack_req", req_n, 0);

        // Call op then back-to-back load
        clr();
        drive(1'b1, 32'h8, 0, 32'h44, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push(0, 32'h8, 32'h44, 4'd15, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h30, 0, 0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_in();
        check("cl_addr", dmem_addr, 32'h30);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        push(32'hCAFEF00D, 32'h30, 0, 4'd2, 1'b1, 1'b1, 1'b0);
        tick();
        dmem_ack = 1'b0;
        tick();
        tick();
        check("cl_stall_cycles", stall_n, 2);

        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
